// File: rtl/commit_trace_source.sv
// commit_trace_source
//   Core-side producer of the commit-trace stream. Each committed instruction
//   from writeback is captured into a small FIFO and drained to the logger over
//   a valid/ready handshake. An ebreak closes the stream: once it has drained,
//   halt is raised. A cycle budget forces halt/timeout if the run never ends.
// Ports
//   clock, reset          single clock, async active-high reset
//   wb_valid/pc/ebreak    writeback commit port
//   trace_valid/ready     handshake toward the logger
//   trace_pc/last         FIFO head payload (zero while trace_valid is low)
//   halt, timeout         sticky end-of-simulation flags
//   drop_count            commits lost to a full FIFO, saturating
//   fifo_level            current FIFO occupancy
module commit_trace_source #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 400000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wb_valid,
  input  logic [DATA_WIDTH-1:0]         wb_pc,
  input  logic                          wb_ebreak,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [DATA_WIDTH-1:0]         trace_pc,
  output logic                          trace_last,
  output logic                          halt,
  output logic                          timeout,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                 state, state_nxt;
  logic                   timeout_set;
  logic [DATA_WIDTH:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;
  logic [CNT_WIDTH-1:0]   cycle_cnt;
  logic                   full, push, pop, accept, drop;
  logic [DATA_WIDTH:0]    head;

  assign head        = mem[rd_ptr];
  assign full        = (level == LW'(FIFO_DEPTH));
  assign trace_valid = (level != '0) && (state != HALTED);
  assign push        = wb_valid && (state == RUN);
  assign pop         = trace_valid && trace_ready;
  // When full, a push only fits because the head leaves in the same cycle.
  assign accept      = push && (!full || pop);
  assign drop        = push && full && !pop;

  // Payload is gated so the logger never sees stale or uninitialised data.
  assign trace_pc    = trace_valid ? head[DATA_WIDTH-1:0] : '0;
  assign trace_last  = trace_valid ? head[DATA_WIDTH] : 1'b0;
  assign halt        = (state == HALTED);
  assign fifo_level  = level;

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      RUN:     if (push && wb_ebreak) state_nxt = DRAIN;
      // Empty FIFO in DRAIN means the ebreak itself was dropped.
      DRAIN:   if ((pop && head[DATA_WIDTH]) || (level == '0)) state_nxt = HALTED;
      default: state_nxt = HALTED;
    endcase
    // Budget expiry overrides everything, including a same-cycle last pop.
    if ((state != HALTED) && (cycle_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1))) begin
      state_nxt   = HALTED;
      timeout_set = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (timeout_set) timeout <= 1'b1;
      if (state != HALTED) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (timeout_set) begin
      // Undrained entries are discarded on timeout.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= {wb_ebreak, wb_pc};
  end

endmodule
